time_set_ctrl: RTL and testbench

TIME_SET_CTRL -- requirements
Module: time_set_ctrl

---
 rtl/time_set_ctrl.sv | 206 ++++++++++++++++++++
 tb/tb_time_set_ctrl.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/time_set_ctrl.sv
// time_set_ctrl: keypad time-entry controller (hh:mm:ss BCD shadow).
// Optional key debounce enabled by defining TIME_SET_DEBOUNCE_EN.
// Ports:
//   clk        in   system clock, rising edge
//   rst        in   synchronous active-high reset
//   set_time   in   entry request, rising edge starts/restarts entry
//   cancel     in   abort entry without load
//   num_input  in   keypad, bit k = digit k pressed
//   busy       out  entry in progress
//   digit_pos  out  next digit position 0..5
//   time_bcd   out  {h_ten,h_one,m_ten,m_one,s_ten,s_one}
//   load       out  one-cycle load strobe
//   err        out  one-cycle rejected-digit pulse
//   blink      out  cursor blink, 250-cycle half period
module time_set_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        set_time,
  input  logic        cancel,
  input  logic [9:0]  num_input,
  output logic        busy,
  output logic [2:0]  digit_pos,
  output logic [23:0] time_bcd,
  output logic        load,
  output logic        err,
  output logic        blink
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_PRESS,
    WAIT_RELEASE,
    COMMIT
  } state_t;

  state_t      state_q;
  logic        busy_q;
  logic [2:0]  pos_q;
  logic [23:0] bcd_q;
  logic        load_q;
  logic        err_q;
  logic        blink_q;
  logic [7:0]  bcnt_q;
  logic        set_q;
  logic        pend_q;
  logic [3:0]  key_q;

  logic        set_rise;
  logic        onehot;
  logic        key_vld;
  logic        rel_ok;
  logic [3:0]  key_dig;
  logic [3:0]  lim;
  logic [23:0] bcd_ins;

  assign set_rise = set_time & ~set_q;
  assign onehot   = $onehot(num_input);

  always_comb begin
    key_dig = '0;
    for (int k = 0; k < 10; k++)
      if (num_input[k]) key_dig = 4'(k);
  end

`ifdef TIME_SET_DEBOUNCE_EN
  // Counts consecutive cycles the keypad has held one value,
  // saturating at 20.
  logic [9:0] db_val_q;
  logic [4:0] db_cnt_q;
  logic [4:0] db_cnt_d;
  logic       stable;

  always_comb begin
    db_cnt_d = 5'd1;
    if (num_input == db_val_q)
      db_cnt_d = (db_cnt_q == 5'd20) ? db_cnt_q
                                     : db_cnt_q + 5'd1;
    stable = (db_cnt_d == 5'd20);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      db_val_q <= '0;
      db_cnt_q <= '0;
    end else begin
      db_val_q <= num_input;
      db_cnt_q <= db_cnt_d;
    end
  end

  assign key_vld = onehot & stable;
  assign rel_ok  = (num_input == '0) & stable;
`else
  assign key_vld = onehot;
  assign rel_ok  = (num_input == '0);
`endif

  // Upper bound of the digit at the current position; hours
  // 20..23 restrict the hour-ones digit.
  always_comb begin
    case (pos_q)
      3'd0:    lim = 4'd2;
      3'd1:    lim = (bcd_q[23:20] == 4'd2) ? 4'd3 : 4'd9;
      3'd2:    lim = 4'd5;
      3'd4:    lim = 4'd5;
      default: lim = 4'd9;
    endcase
  end

  always_comb begin
    bcd_ins = bcd_q;
    for (int p = 0; p < 6; p++)
      if (pos_q == 3'(p)) bcd_ins[23-4*p -: 4] = key_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      pos_q   <= '0;
      bcd_q   <= '0;
      load_q  <= 1'b0;
      err_q   <= 1'b0;
      blink_q <= 1'b0;
      bcnt_q  <= '0;
      set_q   <= 1'b0;
      pend_q  <= 1'b0;
      key_q   <= '0;
    end else begin
      set_q  <= set_time;
      load_q <= 1'b0;
      err_q  <= 1'b0;
      if (busy_q) begin
        if (bcnt_q == 8'd249) begin
          bcnt_q  <= '0;
          blink_q <= ~blink_q;
        end else begin
          bcnt_q <= bcnt_q + 8'd1;
        end
      end
      if (cancel) begin
        if (state_q != IDLE) begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          pos_q   <= '0;
          pend_q  <= 1'b0;
          blink_q <= 1'b0;
          bcnt_q  <= '0;
        end
      end else if (set_rise) begin
        state_q <= WAIT_PRESS;
        busy_q  <= 1'b1;
        pos_q   <= '0;
        bcd_q   <= '0;
        pend_q  <= 1'b0;
        blink_q <= 1'b0;
        bcnt_q  <= '0;
      end else begin
        unique case (state_q)
          IDLE: ;
          WAIT_PRESS: begin
            if (pend_q) begin
              pend_q  <= 1'b0;
              state_q <= WAIT_RELEASE;
              if (key_q <= lim) begin
                bcd_q <= bcd_ins;
                if (pos_q == 3'd5) begin
                  // Last digit: position wraps to 0
                  // as the entry completes.
                  state_q <= COMMIT;
                  load_q  <= 1'b1;
                  pos_q   <= '0;
                end else begin
                  pos_q <= pos_q + 3'd1;
                end
              end else begin
                err_q <= 1'b1;
              end
            end else if (key_vld) begin
              key_q  <= key_dig;
              pend_q <= 1'b1;
            end
          end
          WAIT_RELEASE: begin
            if (rel_ok) state_q <= WAIT_PRESS;
          end
          COMMIT: begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            pos_q   <= '0;
            blink_q <= 1'b0;
            bcnt_q  <= '0;
          end
        endcase
      end
    end
  end

  assign busy      = busy_q;
  assign digit_pos = pos_q;
  assign time_bcd  = bcd_q;
  assign load      = load_q;
  assign err       = err_q;
  assign blink     = blink_q;

endmodule

// File: tb/tb_time_set_ctrl.sv
// tb_time_set_ctrl: scoreboard bench for time_set_ctrl.
// Expected load/err events are queued and matched against a monitor.
module tb_time_set_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        set_time;
  logic        cancel;
  logic [9:0]  num_input;
  logic        busy;
  logic [2:0]  digit_pos;
  logic [23:0] time_bcd;
  logic        load;
  logic        err;
  logic        blink;

  time_set_ctrl dut (
    .clk(clk), .rst(rst), .set_time(set_time),
    .cancel(cancel), .num_input(num_input),
    .busy(busy), .digit_pos(digit_pos),
    .time_bcd(time_bcd), .load(load),
    .err(err), .blink(blink)
  );

  always #5 clk = ~clk;

`ifdef TIME_SET_DEBOUNCE_EN
  localparam int H = 25;
`else
  localparam int H = 3;
`endif

  typedef struct packed {
    logic        is_load;
    logic [23:0] val;
  } ev_t;

  ev_t exp_q[$];
  ev_t obs_q[$];
  int  tests_run = 0;
  int  fails = 0;

  always @(negedge clk) begin
    if (!rst) begin
      if (load) obs_q.push_back({1'b1, time_bcd});
      if (err)  obs_q.push_back({1'b0, 21'b0, digit_pos});
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic start();
    set_time = 1'b1;
    tick(1);
    set_time = 1'b0;
    tick(1);
  endtask

  task automatic press(input int d, input int hold,
                       input int rel);
    num_input = '0;
    num_input[d] = 1'b1;
    tick(hold);
    num_input = '0;
    tick(rel);
  endtask

  task automatic chk(input string nm, input logic [23:0] got,
                     input logic [23:0] want);
    tests_run++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s got %h want %h", nm, got, want);
    end
  endtask

  task automatic drain(input string nm);
    ev_t o, e;
    tests_run++;
    if (obs_q.size() != exp_q.size()) begin
      fails++;
      $display("FAIL %s events got %0d want %0d", nm,
               obs_q.size(), exp_q.size());
    end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      tests_run++;
      if (o !== e) begin
        fails++;
        $display("FAIL %s event got %h want %h", nm, o, e);
      end
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1; set_time = 1'b0; cancel = 1'b0;
    num_input = '0;
    tick(3);
    chk("rst_busy", 24'(busy), 24'h0);
    chk("rst_pos", 24'(digit_pos), 24'h0);
    chk("rst_bcd", time_bcd, 24'h0);
    chk("rst_pulses", {21'b0, load, err, blink}, 24'h0);
    rst = 1'b0;
    tick(2);
  endtask

  task automatic test_full_entry();
    start();
    chk("start_busy", 24'(busy), 24'h1);
    exp_q.push_back({1'b1, 24'h123456});
    for (int d = 1; d <= 6; d++) press(d, H, H);
    chk("full_bcd", time_bcd, 24'h123456);
    chk("full_busy", 24'(busy), 24'h0);
    chk("full_pos", 24'(digit_pos), 24'h0);
    drain("full");
  endtask

  task automatic test_reject();
    start();
    press(2, H, H);
    exp_q.push_back({1'b0, 24'h1});
    press(4, H, H);
    chk("rej_pos", 24'(digit_pos), 24'h1);
    press(3, H, H);
    chk("acc_pos", 24'(digit_pos), 24'h2);
    drain("reject");
  endtask

  task automatic test_held();
    exp_q.push_back({1'b0, 24'h2});
    press(7, 100, H);
    chk("held_rej_pos", 24'(digit_pos), 24'h2);
    press(5, 100, H);
    chk("held_acc_pos", 24'(digit_pos), 24'h3);
    chk("held_bcd", time_bcd, 24'h235000);
    drain("held");
  endtask

  task automatic test_multi();
    num_input = 10'b0000000011;
    tick(10);
    num_input = '0;
    tick(H);
    chk("multi_pos", 24'(digit_pos), 24'h3);
    drain("multi");
  endtask

  task automatic test_cancel_rst();
    cancel = 1'b1;
    tick(1);
    cancel = 1'b0;
    chk("cancel_busy", 24'(busy), 24'h0);
    chk("cancel_bcd", time_bcd, 24'h235000);
    tick(2);
    drain("cancel");
    start();
    for (int d = 1; d <= 4; d++) press(d, H, H);
    chk("pre_rst_pos", 24'(digit_pos), 24'h4);
    chk("pre_rst_bcd", time_bcd, 24'h123400);
    rst = 1'b1; cancel = 1'b1; set_time = 1'b1;
    tick(1);
    chk("mid_rst_bcd", time_bcd, 24'h0);
    chk("mid_rst_out",
        {18'b0, busy, digit_pos, load, err, blink}, 24'h0);
    rst = 1'b0; cancel = 1'b0; set_time = 1'b0;
    tick(2);
    drain("rst");
  endtask

  task automatic test_restart();
    start();
    press(1, H, H);
    press(2, H, H);
    set_time = 1'b1;
    tick(1);
    set_time = 1'b0;
    chk("restart_pos", 24'(digit_pos), 24'h0);
    chk("restart_bcd", time_bcd, 24'h0);
    chk("restart_busy", 24'(busy), 24'h1);
    tick(1);
    exp_q.push_back({1'b0, 24'h0});
    press(3, H, H);
    chk("pos0_rej", 24'(digit_pos), 24'h0);
    cancel = 1'b1; set_time = 1'b1;
    tick(1);
    cancel = 1'b0; set_time = 1'b0;
    chk("cancel_wins", 24'(busy), 24'h0);
    tick(2);
    drain("restart");
  endtask

  task automatic test_blink();
    start();
    tick(248);
    chk("blink_lo", 24'(blink), 24'h0);
    tick(1);
    chk("blink_hi", 24'(blink), 24'h1);
    tick(250);
    chk("blink_lo2", 24'(blink), 24'h0);
    cancel = 1'b1;
    tick(1);
    cancel = 1'b0;
    chk("blink_idle", 24'(blink), 24'h0);
    drain("blink");
  endtask

`ifdef TIME_SET_DEBOUNCE_EN
  task automatic test_debounce();
    start();
    press(1, 10, 25);
    chk("glitch_pos", 24'(digit_pos), 24'h0);
    press(1, 25, 25);
    chk("stable_pos", 24'(digit_pos), 24'h1);
    cancel = 1'b1;
    tick(1);
    cancel = 1'b0;
    drain("debounce");
  endtask
`endif

  initial begin
    #2_000_000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_full_entry();
    test_reject();
    test_held();
    test_multi();
    test_cancel_rst();
    test_restart();
    test_blink();
`ifdef TIME_SET_DEBOUNCE_EN
    test_debounce();
`endif
    $display("[TB] %0d tests run, %0d failed",
             tests_run, fails);
    $finish;
  end

endmodule
